// File: rtl/regfile_pkg.sv
// Shared constants, word type and address-range helper for the multi-port register file.
package regfile_pkg;

    localparam int REGFILE_WIDTH  = 32;
    localparam int REGFILE_DEPTH  = 32;
    localparam int REGFILE_NUM_RD = 2;

    typedef logic [REGFILE_WIDTH-1:0] regfile_word_t;

    // Entry 0 is hardwired to zero, so only 1..depth-1 are real storage.
    function automatic logic regfile_addr_ok(input logic [31:0] addr, input int unsigned depth);
        return (addr != 32'd0) && (addr < depth);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the register file: write port, packed read ports, debug read.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int NUM_RD = REGFILE_NUM_RD
);
    localparam int AW = $clog2(DEPTH);

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic [NUM_RD-1:0]       rd_en;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_valid;
    logic [AW-1:0]           dbg_addr;
    logic [WIDTH-1:0]        dbg_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, dbg_addr,
        input  rd_data, rd_valid, dbg_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, dbg_addr,
        output rd_data, rd_valid, dbg_data
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: address decode with zero/out-of-range masking and optional
// write-to-read forwarding (REGFILE_BYPASS_EN).
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int DEPTH = REGFILE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DEPTH*WIDTH-1:0] mem_i,
    input  logic                   rd_en_i,
    input  logic [AW-1:0]          rd_addr_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   rd_valid_o
);

    logic [WIDTH-1:0] entry_sel;
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_comb begin
        entry_sel = '0;
        if (regfile_addr_ok(32'(rd_addr_i), DEPTH)) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (rd_addr_i == AW'(e)) begin
                    entry_sel = mem_i[e*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the value being written this edge so the read sees the new data.
    always_comb begin
        rd_data_d = entry_sel;
        if (wr_en_i && (wr_addr_i == rd_addr_i) && regfile_addr_ok(32'(wr_addr_i), DEPTH)) begin
            rd_data_d = wr_data_i;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
    assign rd_data_d = entry_sel;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write logic, debug read and NUM_RD read ports.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int NUM_RD = REGFILE_NUM_RD
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH*WIDTH-1:0]  mem_flat;
    logic                    wr_ok;
    logic [WIDTH-1:0]        dbg_sel;
    logic [NUM_RD*WIDTH-1:0] rd_data_w;
    logic [NUM_RD-1:0]       rd_valid_w;

    assign wr_ok = bus.wr_en && regfile_addr_ok(32'(bus.wr_addr), DEPTH);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign mem_flat[WIDTH-1:0] = '0;
            end else begin : g_reg
                logic [WIDTH-1:0] entry_q;
                logic             wr_hit;

                assign wr_hit = wr_ok && (bus.wr_addr == AW'(gi));

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        entry_q <= '0;
                    end else if (wr_hit) begin
                        entry_q <= bus.wr_data;
                    end
                end

                assign mem_flat[gi*WIDTH +: WIDTH] = entry_q;
            end
        end
    endgenerate

    // Debug view reads the stored array only, so it never shows forwarded data.
    always_comb begin
        dbg_sel = '0;
        if (regfile_addr_ok(32'(bus.dbg_addr), DEPTH)) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (bus.dbg_addr == AW'(e)) begin
                    dbg_sel = mem_flat[e*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.dbg_data = dbg_sel;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_rd_port #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_rd_port (
                .clk        (clk),
                .rst        (rst),
                .mem_i      (mem_flat),
                .rd_en_i    (bus.rd_en[gi]),
                .rd_addr_i  (bus.rd_addr[gi*AW +: AW]),
                .wr_en_i    (bus.wr_en),
                .wr_addr_i  (bus.wr_addr),
                .wr_data_i  (bus.wr_data),
                .rd_data_o  (rd_data_w[gi*WIDTH +: WIDTH]),
                .rd_valid_o (rd_valid_w[gi])
            );
        end
    endgenerate

    assign bus.rd_data  = rd_data_w;
    assign bus.rd_valid = rd_valid_w;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (WIDTH=32, DEPTH=24, NUM_RD=4); honours REGFILE_BYPASS_EN.
module tb_regfile_mp;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 24;
    localparam int NUM_RD = 4;
    localparam int AW     = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [31:0] rdp(input int p);
        return bus.rd_data[p*WIDTH +: WIDTH];
    endfunction

    initial begin
        logic [31:0] same_exp;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = '0;   bus.rd_addr = '0; bus.dbg_addr = '0;
        #2;
        check("reset rd_valid", 32'(bus.rd_valid), 32'h0);
        check("reset rd_data0", rdp(0), 32'h0);
        check("reset dbg", bus.dbg_data, 32'h0);
        #1 rst = 1'b0;

        // Basic write then read
        do_write(5, 32'hDEADBEEF);
        bus.rd_en = 4'b0001; set_rd(0, 5);
        bus.dbg_addr = AW'(5);
        tick();
        check("basic rd_data0", rdp(0), 32'hDEADBEEF);
        check("basic rd_valid", 32'(bus.rd_valid), 32'h1);
        check("basic dbg", bus.dbg_data, 32'hDEADBEEF);

        // Entry 0 is hardwired
        bus.rd_en = 4'b0000;
        do_write(0, 32'h12345678);
        bus.rd_en = 4'b1111;
        for (int p = 0; p < NUM_RD; p++) set_rd(p, 0);
        bus.dbg_addr = AW'(0);
        tick();
        for (int p = 0; p < NUM_RD; p++) check($sformatf("zero port%0d", p), rdp(p), 32'h0);
        check("zero rd_valid", 32'(bus.rd_valid), 32'hF);
        check("zero dbg", bus.dbg_data, 32'h0);

        // Fill entries for concurrent reads
        bus.rd_en = 4'b0000;
        tick();
        check("idle rd_valid", 32'(bus.rd_valid), 32'h0);
        do_write(1, 32'hA1);
        do_write(2, 32'hA2);
        do_write(3, 32'hA3);
        do_write(4, 32'hA4);
        do_write(7, 32'h11);
        bus.rd_en = 4'b1111;
        set_rd(0, 4); set_rd(1, 3); set_rd(2, 2); set_rd(3, 2);
        tick();
        check("conc port0", rdp(0), 32'hA4);
        check("conc port1", rdp(1), 32'hA3);
        check("conc port2", rdp(2), 32'hA2);
        check("conc port3", rdp(3), 32'hA2);

        // Idle ports hold data and drop valid
        bus.rd_en = 4'b0000;
        set_rd(0, 1); set_rd(1, 1); set_rd(2, 1); set_rd(3, 1);
        tick();
        check("hold rd_valid", 32'(bus.rd_valid), 32'h0);
        check("hold port0", rdp(0), 32'hA4);
        check("hold port3", rdp(3), 32'hA2);

        // Same-address read and write
`ifdef REGFILE_BYPASS_EN
        same_exp = 32'h22;
`else
        same_exp = 32'h11;
`endif
        bus.rd_en = 4'b0010; set_rd(1, 7);
        bus.dbg_addr = AW'(7);
        #1 check("dbg before write edge", bus.dbg_data, 32'h11);
        do_write(7, 32'h22);
        check("same-addr port1", rdp(1), same_exp);
        check("same-addr valid", 32'(bus.rd_valid), 32'h2);
        check("same-addr dbg", bus.dbg_data, 32'h22);
        tick();
        check("after write port1", rdp(1), 32'h22);

        // Non-power-of-two depth boundaries
        bus.rd_en = 4'b0000;
        do_write(30, 32'h55);
        do_write(24, 32'h66);
        do_write(23, 32'h77);
        bus.rd_en = 4'b0111;
        set_rd(0, 30); set_rd(1, 24); set_rd(2, 23);
        bus.dbg_addr = AW'(30);
        tick();
        check("oor30 rd_data", rdp(0), 32'h0);
        check("oor24 rd_data", rdp(1), 32'h0);
        check("last23 rd_data", rdp(2), 32'h77);
        check("oor rd_valid", 32'(bus.rd_valid), 32'h7);
        check("oor dbg30", bus.dbg_data, 32'h0);
        bus.dbg_addr = AW'(24);
        #1 check("oor dbg24", bus.dbg_data, 32'h0);

        // Reset mid-operation: outputs clear without a clock edge
        bus.rd_en = 4'b1111;
        set_rd(0, 1); set_rd(1, 2); set_rd(2, 3); set_rd(3, 5);
        tick();
        check("pre-rst rd_valid", 32'(bus.rd_valid), 32'hF);
        check("pre-rst port3", rdp(3), 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("async rst rd_valid", 32'(bus.rd_valid), 32'h0);
        check("async rst port0", rdp(0), 32'h0);
        check("async rst port3", rdp(3), 32'h0);
        bus.rd_en = 4'b0000;
        #1 rst = 1'b0;
        for (int a = 1; a < DEPTH; a++) begin
            bus.dbg_addr = AW'(a);
            #1 check($sformatf("post-rst dbg%0d", a), bus.dbg_data, 32'h0);
        end

        // First read after reset
        bus.rd_en = 4'b0001; set_rd(0, 5);
        tick();
        check("post-rst read valid", 32'(bus.rd_valid), 32'h1);
        check("post-rst read data", rdp(0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
